// File: rtl/vdcorput_pkg.sv
// Shared types and constants for the VdCorput sequencer: base encodings,
// controller states and the output FIFO entry layout.
package vdcorput_pkg;

  localparam logic [1:0] BASE2     = 2'b00;
  localparam logic [1:0] BASE3     = 2'b01;
  localparam logic [1:0] BASE7     = 2'b10;
  localparam logic [1:0] BASE_RSVD = 2'b11;

  localparam logic [31:0] FRAC_ONE = 32'h0001_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ACK   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] k;
    logic        last;
  } fifo_entry_t;

endpackage

// File: rtl/vdcorput_seq_fifo.sv
// Count-based synchronous FIFO holding sequencer results; push and pop may
// happen in the same cycle.
module vdcorput_seq_fifo
  import vdcorput_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [$bits(fifo_entry_t)-1:0]  din,
  input  logic                            pop,
  output logic [$bits(fifo_entry_t)-1:0]  dout,
  output logic                            full,
  output logic                            empty
);

  localparam int W  = $bits(fifo_entry_t);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; the depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vdcorput_seq_ctrl.sv
// Initiator-side sequencer: issues consecutive k values to the VdCorput core,
// buffers each result and streams {data, k, last} downstream.
module vdcorput_seq_ctrl
  import vdcorput_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_seed,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [1:0]       cfg_base_sel,
  output logic             busy,
  output logic             finished,
  output logic             cfg_error,
  output logic             core_start,
  output logic [31:0]      core_k,
  output logic [1:0]       core_base_sel,
  input  logic [31:0]      core_result,
  input  logic             core_done,
  input  logic             core_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      out_k,
  output logic             out_last
);

  seq_state_t       state_r, state_s;
  logic [CNT_W-1:0] count_r, issued_r;
  logic [31:0]      core_k_r;
  logic [1:0]       base_r;
  logic             busy_r, finished_r, cfg_error_r;
  logic             accept_s, push_s, pop_s, finish_s, error_s, start_s, last_s;
  logic             fifo_full_s, fifo_empty_s;
  fifo_entry_t      push_entry_s, head_s;
  logic [$bits(fifo_entry_t)-1:0] fifo_dout_s;

  assign last_s   = ((issued_r + CNT_W'(1)) == count_r);
  assign pop_s    = !fifo_empty_s && out_ready;
  assign head_s   = fifo_entry_t'(fifo_dout_s);

  assign busy          = busy_r;
  assign finished      = finished_r;
  assign cfg_error     = cfg_error_r;
  assign core_start    = start_s;
  assign core_k        = core_k_r;
  assign core_base_sel = base_r;
  assign out_valid     = !fifo_empty_s;
  assign out_data      = head_s.data;
  assign out_k         = head_s.k;
  assign out_last      = !fifo_empty_s && head_s.last;

  // Next-state and single-cycle control decode.
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    push_s       = 1'b0;
    finish_s     = 1'b0;
    error_s      = 1'b0;
    start_s      = 1'b0;
    push_entry_s = '{data: core_result, k: core_k_r, last: last_s};
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_base_sel == BASE_RSVD) begin
            error_s = 1'b1;
          end else if (cfg_count == CNT_W'(0)) begin
            finish_s = 1'b1;
          end else begin
            accept_s = 1'b1;
            state_s  = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A free slot is reserved before issuing, so the later push cannot overflow.
        if (core_ready && !fifo_full_s) begin
          start_s = 1'b1;
          state_s = ST_ACK;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_ACK: begin
        // Skip past a done level left over from the previous point.
        if (!core_ready || !core_done) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          push_s  = 1'b1;
          state_s = last_s ? ST_DRAIN : ST_ISSUE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_s.last) begin
          finish_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, run registers and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      issued_r    <= '0;
      core_k_r    <= 32'h0;
      base_r      <= 2'b00;
      busy_r      <= 1'b0;
      finished_r  <= 1'b0;
      cfg_error_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != ST_IDLE);
      finished_r  <= finish_s;
      cfg_error_r <= error_s;
      if (accept_s) begin
        count_r  <= cfg_count;
        issued_r <= '0;
        core_k_r <= cfg_seed;
        base_r   <= cfg_base_sel;
      end else if (push_s) begin
        issued_r <= issued_r + CNT_W'(1);
        core_k_r <= core_k_r + 32'h1;
      end
    end
  end

  vdcorput_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_vdcorput_seq_ctrl.sv
// Directed self-checking bench for vdcorput_seq_ctrl with a behavioural core
// model (pulse or level done) and a stream collector.
module tb_vdcorput_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_seed;
  logic [15:0] cfg_count;
  logic [1:0]  cfg_base_sel;
  logic        busy, finished, cfg_error, core_start;
  logic [31:0] core_k;
  logic [1:0]  core_base_sel;
  logic [31:0] core_result;
  logic        core_done, core_ready;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data, out_k;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int start_cnt = 0;
  int fin_cnt = 0;
  int err_cnt = 0;
  int fin_busy_err = 0;
  int lat_cfg = 3;
  bit done_level = 1'b0;

  logic [31:0] q_data[$];
  logic [31:0] q_k[$];
  logic        q_last[$];

  logic        m_busy;
  int          m_lat;
  logic [31:0] m_k;
  logic [1:0]  m_base;

  always #5 clk = ~clk;

  vdcorput_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_seed(cfg_seed),
    .cfg_count(cfg_count), .cfg_base_sel(cfg_base_sel), .busy(busy),
    .finished(finished), .cfg_error(cfg_error), .core_start(core_start),
    .core_k(core_k), .core_base_sel(core_base_sel), .core_result(core_result),
    .core_done(core_done), .core_ready(core_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_k(out_k), .out_last(out_last)
  );

  function automatic logic [31:0] radinv(input logic [31:0] k, input logic [1:0] b);
    longint unsigned kk;
    longint unsigned base;
    real f;
    real inv;
    kk   = 64'(k);
    base = (b == 2'b01) ? 64'd3 : (b == 2'b10) ? 64'd7 : 64'd2;
    f    = 0.0;
    inv  = 1.0 / real'(base);
    while (kk != 64'd0) begin
      f   = f + real'(kk % base) * inv;
      kk  = kk / base;
      inv = inv / real'(base);
    end
    return 32'($rtoi(f * 65536.0));
  endfunction

  // Core model: accepts a start when ready, answers lat_cfg+1 cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready  <= 1'b1;
      core_done   <= 1'b0;
      core_result <= 32'h0;
      m_busy      <= 1'b0;
      m_lat       <= 0;
      m_k         <= 32'h0;
      m_base      <= 2'b00;
    end else if (core_start && core_ready) begin
      core_ready <= 1'b0;
      core_done  <= 1'b0;
      m_busy     <= 1'b1;
      m_lat      <= lat_cfg;
      m_k        <= core_k;
      m_base     <= core_base_sel;
      start_cnt  <= start_cnt + 1;
    end else if (m_busy) begin
      if (m_lat == 0) begin
        m_busy      <= 1'b0;
        core_ready  <= 1'b1;
        core_done   <= 1'b1;
        core_result <= radinv(m_k, m_base);
      end else begin
        m_lat <= m_lat - 1;
      end
    end else if (!done_level) begin
      core_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_k.push_back(out_k);
      q_last.push_back(out_last);
    end
    if (finished) fin_cnt <= fin_cnt + 1;
    if (cfg_error) err_cnt <= err_cnt + 1;
    if (finished && busy) fin_busy_err <= fin_busy_err + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_k.delete();
    q_last.delete();
  endtask

  task automatic start_run(input logic [31:0] seed, input logic [15:0] cnt, input logic [1:0] base);
    cfg_seed     = seed;
    cfg_count    = cnt;
    cfg_base_sel = base;
    cfg_start    = 1'b1;
    tick();
    cfg_start    = 1'b0;
  endtask

  task automatic wait_finished(input string name, input int budget);
    int f0;
    bit seen;
    f0   = fin_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (fin_cnt > f0) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b1) $display("FAIL %s_timeout: finished seen=%0d required=1", name, seen);
    else pass_cnt++;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    chk_cnt++;
    if ({busy, finished, cfg_error, core_start, out_valid, out_last} !== 6'b0)
      $display("FAIL reset_flags: got %b required 000000",
               {busy, finished, cfg_error, core_start, out_valid, out_last});
    else pass_cnt++;
    chk_cnt++;
    if ({core_k, core_base_sel} !== 34'h0)
      $display("FAIL reset_core_if: got k=%h base=%b required 0", core_k, core_base_sel);
    else pass_cnt++;
  endtask

  task automatic test_base2();
    logic [31:0] exp_d [6];
    int f0;
    exp_d = '{32'h8000, 32'h4000, 32'hC000, 32'h2000, 32'hA000, 32'h6000};
    clear_q();
    f0 = fin_cnt;
    out_ready = 1'b1;
    done_level = 1'b0;
    start_run(32'd1, 16'd6, 2'b00);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL base2_busy_rise: got %b required 1", busy);
    else pass_cnt++;
    wait_finished("base2", 500);
    chk_cnt++;
    if (q_data.size() != 6) $display("FAIL base2_count: got %0d required 6", q_data.size());
    else pass_cnt++;
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      chk_cnt++;
      if ({q_data[i], q_k[i], q_last[i]} !== {exp_d[i], 32'(i + 1), (i == 5)})
        $display("FAIL base2_item%0d: got d=%h k=%h last=%b required d=%h k=%h last=%b",
                 i, q_data[i], q_k[i], q_last[i], exp_d[i], i + 1, (i == 5));
      else pass_cnt++;
    end
    chk_cnt++;
    if (fin_cnt - f0 != 1) $display("FAIL base2_fin_pulses: got %0d required 1", fin_cnt - f0);
    else pass_cnt++;
    chk_cnt++;
    if ({busy, fin_busy_err} !== {1'b0, 32'd0})
      $display("FAIL base2_busy_drop: busy=%b fin_with_busy=%0d required 0/0", busy, fin_busy_err);
    else pass_cnt++;
  endtask

  task automatic test_base3_level();
    logic [31:0] exp_d [3];
    int s0;
    exp_d = '{32'h5555, 32'hAAAA, 32'h1C71};
    clear_q();
    s0 = start_cnt;
    done_level = 1'b1;
    out_ready = 1'b1;
    start_run(32'd1, 16'd3, 2'b01);
    wait_finished("base3", 500);
    repeat (10) tick();
    chk_cnt++;
    if ({32'(q_data.size()), 32'(start_cnt - s0)} !== {32'd3, 32'd3})
      $display("FAIL base3_pushes: items=%0d starts=%0d required 3/3", q_data.size(), start_cnt - s0);
    else pass_cnt++;
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      chk_cnt++;
      if (!(q_data[i] + 32'h100 >= exp_d[i] && q_data[i] <= exp_d[i] + 32'h100) ||
          q_k[i] !== 32'(i + 1) || q_last[i] !== (i == 2))
        $display("FAIL base3_item%0d: got d=%h k=%h last=%b required d=%h(+-100) k=%h last=%b",
                 i, q_data[i], q_k[i], q_last[i], exp_d[i], i + 1, (i == 2));
      else pass_cnt++;
    end
    done_level = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    int s0;
    int unstable;
    bit have_head;
    logic [31:0] head;
    clear_q();
    s0 = start_cnt;
    unstable = 0;
    have_head = 1'b0;
    head = 32'h0;
    out_ready = 1'b0;
    start_run(32'd1, 16'd8, 2'b10);
    repeat (100) begin
      tick();
      if (out_valid && !have_head) begin
        have_head = 1'b1;
        head = out_data;
      end else if (out_valid && out_data !== head) begin
        unstable++;
      end
    end
    chk_cnt++;
    if (start_cnt - s0 != 4) $display("FAIL bp_stall_starts: got %0d required 4", start_cnt - s0);
    else pass_cnt++;
    chk_cnt++;
    if ({out_valid, out_data, 32'(unstable)} !== {1'b1, 32'h2492, 32'd0})
      $display("FAIL bp_head_stable: valid=%b data=%h unstable=%0d required 1/2492/0",
               out_valid, out_data, unstable);
    else pass_cnt++;
    out_ready = 1'b1;
    wait_finished("bp", 1000);
    chk_cnt++;
    if (q_data.size() != 8) $display("FAIL bp_count: got %0d required 8", q_data.size());
    else pass_cnt++;
    for (int i = 0; i < 8 && i < q_k.size(); i++) begin
      chk_cnt++;
      if ({q_k[i], q_last[i]} !== {32'(i + 1), (i == 7)})
        $display("FAIL bp_order%0d: got k=%h last=%b required k=%h last=%b", i, q_k[i], q_last[i], i + 1, (i == 7));
      else pass_cnt++;
    end
    if (q_data.size() >= 2) begin
      chk_cnt++;
      if ({q_data[0], q_data[1]} !== {32'h2492, 32'h4924})
        $display("FAIL bp_data: got %h %h required 2492 4924", q_data[0], q_data[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_empty_and_error();
    int s0;
    int e0;
    int vseen;
    s0 = start_cnt;
    e0 = err_cnt;
    vseen = 0;
    start_run(32'd9, 16'd0, 2'b00);
    chk_cnt++;
    if ({finished, busy} !== 2'b10) $display("FAIL empty_fin: fin=%b busy=%b required 1/0", finished, busy);
    else pass_cnt++;
    repeat (10) begin
      tick();
      if (out_valid || busy || finished) vseen++;
    end
    chk_cnt++;
    if ({32'(vseen), 32'(start_cnt - s0)} !== 64'd0)
      $display("FAIL empty_quiet: activity=%0d starts=%0d required 0/0", vseen, start_cnt - s0);
    else pass_cnt++;
    start_run(32'd1, 16'd5, 2'b11);
    chk_cnt++;
    if ({cfg_error, busy} !== 2'b10) $display("FAIL rsvd_err: err=%b busy=%b required 1/0", cfg_error, busy);
    else pass_cnt++;
    repeat (5) tick();
    chk_cnt++;
    if ({32'(err_cnt - e0), 31'd0, busy} !== {32'd1, 32'd0})
      $display("FAIL rsvd_after: pulses=%0d busy=%b required 1/0", err_cnt - e0, busy);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_q();
    out_ready = 1'b1;
    start_run(32'hFFFF_FFFF, 16'd2, 2'b00);
    wait_finished("wrap", 300);
    chk_cnt++;
    if (q_data.size() != 2) $display("FAIL wrap_count: got %0d required 2", q_data.size());
    else pass_cnt++;
    if (q_data.size() == 2) begin
      chk_cnt++;
      if (q_k[0] !== 32'hFFFF_FFFF || q_last[0] !== 1'b0 || q_data[0] < 32'hFEFF || q_data[0] > 32'h100FF)
        $display("FAIL wrap_first: got d=%h k=%h last=%b required d=FFFF(+-100) k=FFFFFFFF last=0",
                 q_data[0], q_k[0], q_last[0]);
      else pass_cnt++;
      chk_cnt++;
      if ({q_data[1], q_k[1], q_last[1]} !== {32'h0, 32'h0, 1'b1})
        $display("FAIL wrap_second: got d=%h k=%h last=%b required 0/0/1", q_data[1], q_k[1], q_last[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midrun();
    int s0;
    s0 = start_cnt;
    lat_cfg = 5;
    out_ready = 1'b0;
    start_run(32'd1, 16'd8, 2'b00);
    for (int i = 0; i < 300 && (start_cnt - s0) < 3; i++) tick();
    tick();
    tick();
    chk_cnt++;
    if ({out_valid, busy} !== 2'b11) $display("FAIL mid_pre: valid=%b busy=%b required 1/1", out_valid, busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({out_valid, busy, core_start} !== 3'b000)
      $display("FAIL mid_reset: valid=%b busy=%b start=%b required 000", out_valid, busy, core_start);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    lat_cfg = 3;
    tick();
    clear_q();
    out_ready = 1'b1;
    start_run(32'd5, 16'd1, 2'b00);
    wait_finished("mid", 300);
    chk_cnt++;
    if (q_data.size() != 1) $display("FAIL mid_count: got %0d required 1", q_data.size());
    else pass_cnt++;
    if (q_data.size() == 1) begin
      chk_cnt++;
      if ({q_data[0], q_k[0], q_last[0]} !== {32'hA000, 32'd5, 1'b1})
        $display("FAIL mid_item: got d=%h k=%h last=%b required A000/5/1", q_data[0], q_k[0], q_last[0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_seed = 32'h0;
    cfg_count = 16'h0;
    cfg_base_sel = 2'b00;
    out_ready = 1'b1;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_base2();
    test_base3_level();
    test_backpressure();
    test_empty_and_error();
    test_wrap();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
